// File: rtl/load_unit_if.sv
// load_unit_if: groups the load-request side and the data-memory side of the
// load unit into one bundle.
//   core side : start, addr, funct3 -> ; <- busy, done, result, misaligned, timeout_err
//   mem side  : <- mem_req, mem_addr ; mem_ack, mem_rdata ->
// Modports: slave = the load unit itself, master = whoever drives it (core + memory).
interface load_unit_if #(parameter int ADDR_WIDTH = 32) ();
  logic                  start;
  logic [ADDR_WIDTH-1:0] addr;
  logic [2:0]            funct3;
  logic                  busy;
  logic                  done;
  logic [31:0]           result;
  logic                  misaligned;
  logic                  timeout_err;
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_ack;
  logic [31:0]           mem_rdata;

  modport slave (
    input  start, addr, funct3, mem_ack, mem_rdata,
    output busy, done, result, misaligned, timeout_err, mem_req, mem_addr
  );

  modport master (
    output start, addr, funct3, mem_ack, mem_rdata,
    input  busy, done, result, misaligned, timeout_err, mem_req, mem_addr
  );
endinterface

// File: rtl/load_unit.sv
// load_unit: executes RV32I loads (LB/LH/LW/LBU/LHU) against data memory over
// a req/ack handshake, extracts and sign/zero-extends the addressed lane and
// holds it in result for write-back.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : load_unit_if.slave (request/status toward the core, req/ack
//              toward data memory)
// Flow: IDLE -> REQ -> FIN -> IDLE, or IDLE -> FIN directly when the request
// is misaligned or has an illegal funct3 (memory is never touched then).
module load_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input logic        clk,
  input logic        rst,
  load_unit_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, FIN} state_t;

  state_t                state, state_nxt;
  logic [2:0]            f3_q;
  logic [1:0]            off_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [31:0]           result_q;
  logic                  misaligned_q;
  logic                  timeout_q;
  logic [CW-1:0]         cnt;
  logic                  bad_req;

  // Illegal encodings and misaligned halves/words are rejected up front.
  always_comb begin
    bad_req = 1'b0;
    case (bus.funct3)
      3'b000, 3'b100: bad_req = 1'b0;
      3'b001, 3'b101: bad_req = bus.addr[0];
      3'b010:         bad_req = |bus.addr[1:0];
      default:        bad_req = 1'b1;
    endcase
  end

  function automatic logic [31:0] extract(input logic [2:0]  f3,
                                          input logic [1:0]  off,
                                          input logic [31:0] rdata);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    sh = rdata >> {off, 3'b000};
    b  = sh[7:0];
    h  = off[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      3'b000:  extract = {{24{b[7]}}, b};
      3'b100:  extract = {24'd0, b};
      3'b001:  extract = {{16{h[15]}}, h};
      3'b101:  extract = {16'd0, h};
      default: extract = rdata;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = bad_req ? FIN : REQ;
      REQ:  if (bus.mem_ack || cnt == CNT_LAST) state_nxt = FIN;
      FIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      f3_q         <= 3'd0;
      off_q        <= 2'd0;
      mem_addr_q   <= '0;
      result_q     <= 32'd0;
      misaligned_q <= 1'b0;
      timeout_q    <= 1'b0;
      cnt          <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          f3_q         <= bus.funct3;
          off_q        <= bus.addr[1:0];
          mem_addr_q   <= {bus.addr[ADDR_WIDTH-1:2], 2'b00};
          misaligned_q <= bad_req;
          timeout_q    <= 1'b0;
          cnt          <= '0;
          if (bad_req) result_q <= 32'd0;
        end
        REQ: begin
          if (bus.mem_ack)          result_q  <= extract(f3_q, off_q, bus.mem_rdata);
          else if (cnt == CNT_LAST) timeout_q <= 1'b1;  // result keeps old value
          else                      cnt       <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state != IDLE);
  assign bus.done        = (state == FIN);
  assign bus.mem_req     = (state == REQ);
  assign bus.mem_addr    = mem_addr_q;
  assign bus.result      = result_q;
  assign bus.misaligned  = misaligned_q;
  assign bus.timeout_err = timeout_q;

endmodule

// File: tb/tb_load_unit.sv
// Directed bench for load_unit: reset, aligned loads with lane extraction,
// misaligned/illegal rejection, memory timeout, and START while busy.
module tb_load_unit;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  load_unit_if #(.ADDR_WIDTH(32)) bus ();

  load_unit #(.ADDR_WIDTH(32), .TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // results of the last run_load
  int          lat, nreq, ndone;
  logic [31:0] addr_seen, res, prev;
  logic        mis, tmo, saw_req;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one load, answers mem_req after ack_dly REQ cycles with rdata,
  // and records latency (cycles from the START edge to DONE) and flags.
  task automatic run_load(input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] rd, input int ack_dly, input bit hold_start);
    int rq;
    lat = 0; nreq = 0; ndone = 0; saw_req = 0; addr_seen = 'x; rq = 0;
    bus.funct3 = f3; bus.addr = a; bus.start = 1'b1;
    step();
    if (!hold_start) bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 60) begin
      if (bus.mem_req) begin
        saw_req = 1;
        addr_seen = bus.mem_addr;
        if (rq >= ack_dly) begin
          bus.mem_ack = 1'b1;
          bus.mem_rdata = rd;
        end
        rq++;
      end
      step();
      bus.mem_ack = 1'b0;
      bus.mem_rdata = 32'h0;
      lat++;
    end
    nreq = rq;
    if (bus.done) ndone = 1;
    else begin
      errors++;
      $display("FAIL done_timeout: got no DONE within %0d cycles, required DONE", lat);
    end
    res = bus.result; mis = bus.misaligned; tmo = bus.timeout_err;
    step();
    bus.start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 0; bus.addr = 0; bus.funct3 = 0; bus.mem_ack = 0; bus.mem_rdata = 0;
    step(); step();
    rst = 1'b0;
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_req",  32'(bus.mem_req), 0);
    check("rst_result", bus.result, 0);
    check("rst_maddr", bus.mem_addr, 0);
    check("rst_flags", {30'd0, bus.misaligned, bus.timeout_err}, 0);

    // LW aligned, ack on first REQ cycle
    run_load(3'b010, 32'h100, 32'hDEADBEEF, 0, 0);
    check("lw_lat", lat, 2);
    check("lw_maddr", addr_seen, 32'h100);
    check("lw_result", res, 32'hDEADBEEF);
    check("lw_flags", {30'd0, mis, tmo}, 0);

    // reset mid-REQ
    bus.funct3 = 3'b010; bus.addr = 32'h200; bus.start = 1;
    step(); bus.start = 0;
    step();
    check("mid_req_active", 32'(bus.mem_req), 1);
    rst = 1'b1; step(); step(); rst = 1'b0;
    check("mid_rst_req", 32'(bus.mem_req), 0);
    check("mid_rst_busy", 32'(bus.busy), 0);
    check("mid_rst_result", bus.result, 0);
    check("mid_rst_done", 32'(bus.done), 0);
    step();
    check("mid_rst_nodone", 32'(bus.done), 0);

    // lane extraction from 0x80FF7F01
    run_load(3'b000, 32'h103, 32'h80FF7F01, 0, 0);
    check("lb103", res, 32'hFFFFFF80);  check("lb103_maddr", addr_seen, 32'h100);
    run_load(3'b100, 32'h103, 32'h80FF7F01, 0, 0);
    check("lbu103", res, 32'h00000080); check("lbu103_maddr", addr_seen, 32'h100);
    run_load(3'b001, 32'h102, 32'h80FF7F01, 0, 0);
    check("lh102", res, 32'hFFFF80FF);  check("lh102_maddr", addr_seen, 32'h100);
    run_load(3'b101, 32'h100, 32'h80FF7F01, 0, 0);
    check("lhu100", res, 32'h00007F01); check("lhu100_maddr", addr_seen, 32'h100);
    run_load(3'b000, 32'h101, 32'h80FF7F01, 1, 0);
    check("lb101", res, 32'h0000007F);  check("lb101_lat", lat, 3);
    run_load(3'b100, 32'h102, 32'h80FF7F01, 0, 0);
    check("lbu102", res, 32'h000000FF);

    // misaligned / illegal: DONE next cycle, no memory traffic, result cleared
    run_load(3'b010, 32'h102, 32'h12345678, 0, 0);
    check("lw102_lat", lat, 1); check("lw102_req", 32'(saw_req), 0);
    check("lw102_mis", 32'(mis), 1); check("lw102_res", res, 0);
    run_load(3'b001, 32'h101, 32'h12345678, 0, 0);
    check("lh101_lat", lat, 1); check("lh101_req", 32'(saw_req), 0);
    check("lh101_mis", 32'(mis), 1);
    run_load(3'b011, 32'h100, 32'h12345678, 0, 0);
    check("f3_011_mis", 32'(mis), 1); check("f3_011_req", 32'(saw_req), 0);
    check("f3_011_tmo", 32'(tmo), 0);
    run_load(3'b101, 32'h103, 32'h12345678, 0, 0);
    check("lhu103_mis", 32'(mis), 1);

    // flags clear on next accepted START
    run_load(3'b010, 32'h104, 32'hCAFEF00D, 0, 0);
    check("lw104_mis_clr", 32'(mis), 0); check("lw104_res", res, 32'hCAFEF00D);
    check("lw104_maddr", addr_seen, 32'h104);

    // timeout: no ack
    prev = bus.result;
    run_load(3'b010, 32'h108, 32'h0, 1000, 0);
    check("to_req_cycles", nreq, 16);
    check("to_lat", lat, 17);
    check("to_err", 32'(tmo), 1);
    check("to_mis", 32'(mis), 0);
    check("to_result_held", res, prev);
    bus.mem_ack = 1; bus.mem_rdata = 32'h55555555;
    step(); step();
    bus.mem_ack = 0;
    check("late_ack_busy", 32'(bus.busy), 0);
    check("late_ack_done", 32'(bus.done), 0);
    check("late_ack_result", bus.result, prev);

    // START held every cycle, ack delayed 3 REQ cycles
    run_load(3'b010, 32'h10C, 32'h0BADC0DE, 3, 1);
    check("busy_start_reqs", nreq, 4);
    check("busy_start_lat", lat, 5);
    check("busy_start_res", res, 32'h0BADC0DE);
    // start was still high during FIN; it must have been ignored
    check("fin_start_ignored", 32'(bus.busy), 0);
    ndone = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.done) ndone++;
      step();
    end
    check("single_done", ndone, 0);
    bus.funct3 = 3'b010; bus.addr = 32'h110; bus.start = 1;
    step(); bus.start = 0;
    check("idle_accept", 32'(bus.mem_req), 1);
    check("idle_accept_maddr", bus.mem_addr, 32'h110);
    bus.mem_ack = 1; bus.mem_rdata = 32'h01020304;
    step(); bus.mem_ack = 0;
    check("idle_accept_done", 32'(bus.done), 1);
    check("idle_accept_res", bus.result, 32'h01020304);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end
endmodule
